// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the prefetching fetch unit.
//   fetch_state_e : top-level FSM encoding (BOOT / RUN / FLUSH)
//   fetch_entry_t : {pc, inst} pair as delivered to decode (default XLEN=32 layout)
//   INST_BYTES    : instruction size in bytes; PC step between sequential fetches
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Parametrised synchronous FIFO used as the prefetch buffer.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push, i_data  write one entry (ignored when full)
//   i_pop           drop the head entry (ignored when empty)
//   i_clear         empty the FIFO; wins over push/pop in the same cycle
//   o_data          head entry, read combinationally from storage
//   o_empty         no valid entries
//   o_count         number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != FULL_CNT);
  assign w_pop   = i_pop && (r_count != ZERO_CNT);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == ZERO_CNT);
  assign o_count = r_count;

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers and occupancy; clear takes priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= ZERO_CNT;
    end else if (i_clear) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= ZERO_CNT;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
// Fetch stage that decouples PC generation from a latency-tolerant instruction
// memory. Requests go out in order, responses land in a prefetch FIFO and are
// handed to decode as {pc, instruction} pairs. A redirect flushes the FIFO and
// squashes every response still owed by memory for the old path.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   redirect_valid, redirect_pc       new fetch PC (low two bits ignored)
//   imem_req_valid/ready/addr         request channel to instruction memory
//   imem_rsp_valid/data               in-order response channel
//   inst_valid/ready, inst_data/pc    FIFO head towards decode
//   perf_fetched, perf_squashed       (FETCH_PERF_CNT_EN only) counts of
//                                     accepted and discarded responses
//
// Optional feature macro: FETCH_PERF_CNT_EN
// -----------------------------------------------------------------------------
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     MAX_OUTST  = 4,
  parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed
`endif
);

  localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     SW         = CW + 1;
  localparam int unsigned     EW         = XLEN + 32;
  localparam logic [CW-1:0]   ZERO_CNT   = {CW{1'b0}};
  localparam logic [CW-1:0]   MAX_OUTST_C = CW'(MAX_OUTST);
  localparam logic [SW-1:0]   DEPTH_C    = SW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_outst_next;
  logic [CW-1:0]   w_drop_next;
  logic [XLEN-1:0] r_last_pc;
  logic [31:0]     r_last_inst;

  logic [XLEN-1:0] w_redirect_aligned;
  logic            w_req_hs;
  logic            w_rsp_drop;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_fifo_wdata;
  logic [EW-1:0]   w_fifo_head;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;
  logic [SW-1:0]   w_credit_used;

  assign w_redirect_aligned = redirect_pc & ALIGN_MASK;
  assign w_req_hs           = imem_req_valid && imem_req_ready;
  // A response is discarded if it belongs to a squashed request, or if it
  // arrives in the very cycle of a redirect (its path is being abandoned).
  assign w_rsp_drop         = imem_rsp_valid && (redirect_valid || (r_drop_cnt != ZERO_CNT));
  assign w_push             = imem_rsp_valid && !w_rsp_drop;
  // The FIFO is cleared on redirect, so a same-cycle pop must not count.
  assign w_pop              = inst_valid && inst_ready && !redirect_valid;
  assign w_fifo_wdata       = {r_rsp_pc, imem_rsp_data};
  // Every outstanding request holds a reserved FIFO slot, so the FIFO can
  // never be pushed while full.
  assign w_credit_used      = {1'b0, r_outst} + {1'b0, w_fifo_count};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_fifo_wdata),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Request channel: issue only outside BOOT and while credit remains.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = r_req_pc;
    if ((r_state != BOOT) && (r_outst < MAX_OUTST_C) && (w_credit_used < DEPTH_C)) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  // Decode-facing outputs: FIFO head, or the last popped pair when empty.
  always_comb begin
    inst_valid = !w_fifo_empty;
    inst_pc    = r_last_pc;
    inst_data  = r_last_inst;
    if (!w_fifo_empty) begin
      inst_pc   = w_fifo_head[EW-1:32];
      inst_data = w_fifo_head[31:0];
    end else begin
      inst_pc   = r_last_pc;
      inst_data = r_last_inst;
    end
  end

  // Outstanding-request and squash counters for the coming cycle.
  always_comb begin
    w_outst_next = r_outst;
    case ({w_req_hs, imem_rsp_valid})
      2'b10:   w_outst_next = r_outst + CW'(1);
      2'b01:   w_outst_next = r_outst - CW'(1);
      default: w_outst_next = r_outst;
    endcase
    // On redirect every request still owed by memory is stale, including one
    // accepted this cycle and excluding a response consumed this cycle; that
    // is exactly the next outstanding count.
    w_drop_next = r_drop_cnt;
    if (redirect_valid) begin
      w_drop_next = w_outst_next;
    end else if (w_rsp_drop) begin
      w_drop_next = r_drop_cnt - CW'(1);
    end else begin
      w_drop_next = r_drop_cnt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT: begin
        w_state_next = RUN;
      end
      RUN: begin
        if (redirect_valid && (w_drop_next != ZERO_CNT)) begin
          w_state_next = FLUSH;
        end else begin
          w_state_next = RUN;
        end
      end
      FLUSH: begin
        if (w_drop_next == ZERO_CNT) begin
          w_state_next = RUN;
        end else begin
          w_state_next = FLUSH;
        end
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  // FSM state and credit/squash counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_outst    <= ZERO_CNT;
      r_drop_cnt <= ZERO_CNT;
    end else begin
      r_state    <= w_state_next;
      r_outst    <= w_outst_next;
      r_drop_cnt <= w_drop_next;
    end
  end

  // Request and response PCs; redirect overrides sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_pc <= RESET_PC;
      r_rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_req_pc <= w_redirect_aligned;
      r_rsp_pc <= w_redirect_aligned;
    end else begin
      if (w_req_hs) begin
        r_req_pc <= r_req_pc + PC_STEP;
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + PC_STEP;
      end
    end
  end

  // Last pair handed to decode, shown while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_pc   <= RESET_PC;
      r_last_inst <= 32'h0000_0000;
    end else if (w_pop) begin
      r_last_pc   <= w_fifo_head[EW-1:32];
      r_last_inst <= w_fifo_head[31:0];
    end else begin
      r_last_pc   <= r_last_pc;
      r_last_inst <= r_last_inst;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: accepted and discarded responses, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched  <= 32'd0;
      perf_squashed <= 32'd0;
    end else begin
      if (w_push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (w_rsp_drop) begin
        perf_squashed <= perf_squashed + 32'd1;
      end
    end
  end
`endif

endmodule
